// File: rtl/arith_pkg.sv
// Shared types and constants for the sequential divider.
package arith_pkg;

    localparam int ARITH_DIV_WIDTH_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

endpackage

// File: rtl/arith_div_seq_if.sv
// Request/result handshake bundle for the sequential divider.
interface arith_div_seq_if
    import arith_pkg::*;
#(
    parameter int WIDTH = ARITH_DIV_WIDTH_DEFAULT
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             is_signed;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] quot;
    logic [WIDTH-1:0] rem;
    logic             div_by_zero;

    modport master (
        output in_valid, a, b, is_signed, out_ready,
        input  in_ready, out_valid, quot, rem, div_by_zero
    );

    modport slave (
        input  in_valid, a, b, is_signed, out_ready,
        output in_ready, out_valid, quot, rem, div_by_zero
    );
endinterface

// File: rtl/arith_div_step.sv
// One restoring-division iteration: shift, trial subtract, restore, quotient bit.
module arith_div_step #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] rem_in,
    input  logic [WIDTH-1:0] dvd_in,
    input  logic [WIDTH-1:0] dsr,
    output logic [WIDTH-1:0] rem_out,
    output logic [WIDTH-1:0] dvd_out
);
    logic [WIDTH:0]   sh;
    logic [WIDTH+1:0] diff;
    logic             qbit;

    assign sh   = {rem_in, dvd_in[WIDTH-1]};
    assign diff = {1'b0, sh} - {2'b00, dsr};
    // a successful trial always leaves a difference that fits in WIDTH bits
    assign qbit = ~|diff[WIDTH+1:WIDTH];

    assign rem_out = qbit ? diff[WIDTH-1:0] : sh[WIDTH-1:0];
    assign dvd_out = {dvd_in[WIDTH-2:0], qbit};
endmodule

// File: rtl/arith_div_seq.sv
// Sequential restoring divider, one quotient bit per cycle.
// Signed operation is compiled in with ARITH_DIV_SIGNED_EN.
module arith_div_seq
    import arith_pkg::*;
#(
    parameter int WIDTH = ARITH_DIV_WIDTH_DEFAULT
) (
    input logic clk,
    input logic reset,
    arith_div_seq_if.slave bus
);
    localparam int CW = $clog2(WIDTH);

    state_t           state;
    state_t           state_nx;
    logic [CW-1:0]    cnt;
    logic             last;
    logic [WIDTH-1:0] dvd;
    logic [WIDTH-1:0] part;
    logic [WIDTH-1:0] dsr;
    logic             dbz;
    logic [WIDTH-1:0] st_rem;
    logic [WIDTH-1:0] st_dvd;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH-1:0] q_fix;
    logic [WIDTH-1:0] r_fix;
    logic [WIDTH-1:0] quot_r;
    logic [WIDTH-1:0] rem_r;
    logic             dbz_r;
    logic             accept;

`ifdef ARITH_DIV_SIGNED_EN
    logic sa;
    logic sb;
    logic qs;
    logic rs;

    assign sa    = bus.is_signed & bus.a[WIDTH-1];
    assign sb    = bus.is_signed & bus.b[WIDTH-1];
    assign a_mag = sa ? -bus.a : bus.a;
    assign b_mag = sb ? -bus.b : bus.b;
    assign q_fix = qs ? -dvd : dvd;
    assign r_fix = rs ? -part : part;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            qs <= 1'b0;
            rs <= 1'b0;
        end else if (accept) begin
            qs <= sa ^ sb;
            rs <= sa;
        end
    end
`else
    assign a_mag = bus.a;
    assign b_mag = bus.b;
    assign q_fix = dvd;
    assign r_fix = part;
`endif

    assign accept          = bus.in_valid & bus.in_ready;
    assign bus.in_ready    = (state == IDLE) & ~reset;
    assign bus.out_valid   = (state == DONE);
    assign bus.quot        = quot_r;
    assign bus.rem         = rem_r;
    assign bus.div_by_zero = dbz_r;

    arith_div_step #(.WIDTH(WIDTH)) u_step (
        .rem_in  (part),
        .dvd_in  (dvd),
        .dsr     (dsr),
        .rem_out (st_rem),
        .dvd_out (st_dvd)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (accept) state_nx = BUSY;
            BUSY:    if (last) state_nx = DONE;
            DONE:    if (bus.out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt    <= '0;
            last   <= 1'b0;
            dvd    <= '0;
            part   <= '0;
            dsr    <= '0;
            dbz    <= 1'b0;
            quot_r <= '0;
            rem_r  <= '0;
            dbz_r  <= 1'b0;
        end else if (accept) begin
            dvd  <= a_mag;
            dsr  <= b_mag;
            part <= '0;
            dbz  <= (bus.b == '0);
            cnt  <= CW'(WIDTH - 1);
            last <= 1'b0;
        end else if (state == BUSY) begin
            if (!last) begin
                part <= st_rem;
                dvd  <= st_dvd;
                if (cnt == '0) last <= 1'b1;
                else           cnt  <= cnt - 1'b1;
            end else begin
                // divide by zero keeps the raw all-ones quotient unsigned
                quot_r <= dbz ? '1 : q_fix;
                rem_r  <= r_fix;
                dbz_r  <= dbz;
                last   <= 1'b0;
            end
        end
    end
endmodule
